// File: rtl/imu_spi_seq_pkg.sv
// Shared types and default command words for the IMU SPI sequencer.
// The FSM state encoding and the init/read commands live here so the bench can reuse them.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SND,
    INIT_WAIT,
    INT_WAIT,
    LO_SND,
    LO_WAIT,
    HI_SND,
    HI_WAIT
  } state_t;

  localparam logic [15:0] DEF_INIT_CMD0 = 16'h0D02;
  localparam logic [15:0] DEF_INIT_CMD1 = 16'h1160;
  localparam logic [15:0] DEF_INIT_CMD2 = 16'h1440;
  localparam logic [15:0] DEF_RD_LO_CMD = 16'hA600;
  localparam logic [15:0] DEF_RD_HI_CMD = 16'hA700;

  function automatic logic [15:0] init_cmd_sel(input logic [1:0] step,
                                               input logic [15:0] c0,
                                               input logic [15:0] c1,
                                               input logic [15:0] c2);
    case (step)
      2'd0:    return c0;
      2'd1:    return c1;
      default: return c2;
    endcase
  endfunction

endpackage

// File: rtl/imu_spi_seq_if.sv
// Handshake bundle between the sequencer and the 16-bit SPI master.
// done is a level that stays high until the next snd; resp is valid while done is high.
interface imu_spi_seq_if;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output snd, output cmd, input done, input resp);
  modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/imu_spi_seq.sv
// IMU bring-up and yaw-rate streaming sequencer: power-up wait, three init writes,
// then per data-ready interrupt two byte reads assembled into one 16-bit sample.
module imu_spi_seq
  import imu_seq_pkg::*;
#(
  parameter int          PWR_WAIT_W = 16,
  parameter logic [15:0] INIT_CMD0  = DEF_INIT_CMD0,
  parameter logic [15:0] INIT_CMD1  = DEF_INIT_CMD1,
  parameter logic [15:0] INIT_CMD2  = DEF_INIT_CMD2,
  parameter logic [15:0] RD_LO_CMD  = DEF_RD_LO_CMD,
  parameter logic [15:0] RD_HI_CMD  = DEF_RD_HI_CMD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                INT,
  imu_spi_seq_if.master       spi,
  output logic [15:0]         yaw_rt,
  output logic                vld,
  output logic                init_done
);

  state_t                state;
  logic [PWR_WAIT_W-1:0] pwr_cnt;
  logic [1:0]            step;
  logic [7:0]            lo_byte;
  logic                  int_p0;
  logic                  int_p1;
  logic                  done_ff;
  logic                  done_rise;

  // Stage p0/p1: INT synchronizer; done_ff tracks the done level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_p0  <= 1'b0;
      int_p1  <= 1'b0;
      done_ff <= 1'b0;
    end else begin
      int_p0  <= INT;
      int_p1  <= int_p0;
      done_ff <= spi.done;
    end
  end

  // done stays high from the previous transaction, so only its rising edge means completion
  assign done_rise = spi.done & ~done_ff;

  // snd is raised on the transition into a *_SND state, so it is high exactly while in that state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      pwr_cnt   <= '0;
      step      <= 2'd0;
      lo_byte   <= 8'h00;
      spi.snd   <= 1'b0;
      spi.cmd   <= 16'h0000;
      yaw_rt    <= 16'h0000;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      spi.snd <= 1'b0;
      vld     <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (&pwr_cnt) begin
            pwr_cnt <= '0;
            step    <= 2'd0;
            spi.snd <= 1'b1;
            spi.cmd <= INIT_CMD0;
            state   <= INIT_SND;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        INIT_SND: state <= INIT_WAIT;
        INIT_WAIT: begin
          if (done_rise) begin
            if (step == 2'd2) begin
              init_done <= 1'b1;
              state     <= INT_WAIT;
            end else begin
              step    <= step + 2'd1;
              spi.snd <= 1'b1;
              spi.cmd <= init_cmd_sel(step + 2'd1, INIT_CMD0, INIT_CMD1, INIT_CMD2);
              state   <= INIT_SND;
            end
          end
        end
        INT_WAIT: begin
          if (int_p1) begin
            spi.snd <= 1'b1;
            spi.cmd <= RD_LO_CMD;
            state   <= LO_SND;
          end
        end
        LO_SND: state <= LO_WAIT;
        LO_WAIT: begin
          if (done_rise) begin
            lo_byte <= spi.resp[7:0];
            spi.snd <= 1'b1;
            spi.cmd <= RD_HI_CMD;
            state   <= HI_SND;
          end
        end
        HI_SND: state <= HI_WAIT;
        HI_WAIT: begin
          if (done_rise) begin
            yaw_rt <= {spi.resp[7:0], lo_byte};
            vld    <= 1'b1;
            state  <= INT_WAIT;
          end
        end
        default: begin
          pwr_cnt <= '0;
          state   <= PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_seq.sv
// Directed bench for imu_spi_seq with an SPI slave model and command/sample scoreboards.
module tb_imu_spi_seq;
  import imu_seq_pkg::*;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_in = 1'b0;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  imu_spi_seq_if spi_bus ();

  imu_spi_seq #(.PWR_WAIT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (int_in),
    .spi       (spi_bus),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_yaw_q[$];
  logic [7:0]  resp_q[$];

  bit          busy = 1'b0;
  bit          stale = 1'b0;
  bit          first_armed = 1'b0;
  bit          prev_vld = 1'b0;
  bit          prev_init = 1'b0;
  int          cnt = 0;
  int          hold = 0;
  int          rise_cyc = 0;
  int          rise_cnt = 0;
  int          first_snd_cyc = 0;
  int          snd_cnt = 0;
  int          rd_lo_cnt = 0;
  int          hi_snd_cnt = 0;
  int          vld_cnt = 0;
  int          last_vld_cyc = 0;
  int          vld_gap = 0;
  logic [15:0] pend_resp = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave model: done falls on snd (or later in stale mode) and rises LAT cycles after it
  always @(negedge clk) begin
    if (!rst_n) begin
      busy         = 1'b0;
      spi_bus.done = 1'b0;
      spi_bus.resp = 16'h0000;
      hold         = 0;
      cnt          = 0;
      rise_cnt     = 0;
      prev_init    = 1'b0;
    end else begin
      if (busy) begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) spi_bus.done = 1'b0;
        end
        cnt--;
        if (cnt == 0) begin
          spi_bus.done = 1'b1;
          spi_bus.resp = pend_resp;
          busy         = 1'b0;
          rise_cyc     = cyc;
          rise_cnt++;
        end
      end
      if (spi_bus.snd) begin
        snd_cnt++;
        chk("snd_while_busy", busy, 0);
        if (first_armed) begin
          first_snd_cyc = cyc;
          first_armed   = 1'b0;
        end
        chk("cmd_expected", exp_cmd_q.size() > 0, 1);
        if (exp_cmd_q.size() > 0) chk("cmd", spi_bus.cmd, exp_cmd_q.pop_front());
        chk("init_done_at_snd", init_done, spi_bus.cmd[15]);
        if (spi_bus.cmd == DEF_RD_LO_CMD) rd_lo_cnt++;
        if (spi_bus.cmd == DEF_RD_HI_CMD) hi_snd_cnt++;
        if (spi_bus.cmd == DEF_INIT_CMD1 || spi_bus.cmd == DEF_INIT_CMD2 ||
            spi_bus.cmd == DEF_RD_HI_CMD)
          chk("snd_after_rise", cyc - rise_cyc, 1);
        if (spi_bus.cmd[15] && resp_q.size() > 0)
          pend_resp = {8'($urandom_range(0, 255)), resp_q.pop_front()};
        else
          pend_resp = 16'h0000;
        busy = 1'b1;
        cnt  = LAT;
        if (stale) hold = 3;
        else spi_bus.done = 1'b0;
      end
      if (init_done && !prev_init) begin
        chk("init_done_rises", rise_cnt, 3);
        chk("init_done_lat", cyc - rise_cyc, 1);
      end
      prev_init = init_done;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (vld) begin
        vld_cnt++;
        chk("vld_one_cycle", prev_vld, 0);
        chk("yaw_expected", exp_yaw_q.size() > 0, 1);
        if (exp_yaw_q.size() > 0) chk("yaw", yaw_rt, exp_yaw_q.pop_front());
        vld_gap      = cyc - last_vld_cyc;
        last_vld_cyc = cyc;
      end
      prev_vld = vld;
    end else begin
      prev_vld = 1'b0;
    end
  end

  task automatic wait_vld(input int target, input int budget);
    for (int i = 0; i < budget && vld_cnt < target; i++) @(negedge clk);
    chk("vld_timeout", vld_cnt >= target, 1);
  endtask

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget && !init_done; i++) @(negedge clk);
    chk("init_timeout", init_done, 1);
  endtask

  task automatic push_init;
    exp_cmd_q.push_back(DEF_INIT_CMD0);
    exp_cmd_q.push_back(DEF_INIT_CMD1);
    exp_cmd_q.push_back(DEF_INIT_CMD2);
  endtask

  task automatic push_read(input logic [7:0] lo, input logic [7:0] hi);
    resp_q.push_back(lo);
    resp_q.push_back(hi);
    exp_cmd_q.push_back(DEF_RD_LO_CMD);
    exp_cmd_q.push_back(DEF_RD_HI_CMD);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_snd"}, spi_bus.snd, 0);
    chk({tag, "_cmd"}, spi_bus.cmd, 16'h0000);
    chk({tag, "_yaw"}, yaw_rt, 16'h0000);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_init_done"}, init_done, 0);
  endtask

  initial begin
    int r;
    int t0;
    int h0;
    int v0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    push_init();
    first_armed = 1'b1;
    rst_n = 1'b1;
    r = cyc;
    wait_init(200);
    chk("pwr_wait", (first_snd_cyc - r) inside {[16:17]}, 1);
    chk("init_snd_count", snd_cnt, 3);

    repeat (30) @(negedge clk);
    chk("no_snd_int_low", snd_cnt, 3);

    push_read(8'h34, 8'h12);
    exp_yaw_q.push_back(16'h1234);
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    int_in = 1'b0;
    wait_vld(1, 100);
    repeat (5) @(negedge clk);
    chk("yaw_hold", yaw_rt, 16'h1234);

    stale = 1'b1;
    push_read(8'hCD, 8'hAB);
    exp_yaw_q.push_back(16'hABCD);
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    int_in = 1'b0;
    wait_vld(2, 100);
    stale = 1'b0;
    repeat (5) @(negedge clk);

    push_read(8'hFF, 8'hFF);
    push_read(8'h01, 8'h00);
    exp_yaw_q.push_back(16'hFFFF);
    exp_yaw_q.push_back(16'h0001);
    t0 = rd_lo_cnt;
    int_in = 1'b1;
    for (int i = 0; i < 200 && rd_lo_cnt < t0 + 2; i++) @(negedge clk);
    int_in = 1'b0;
    wait_vld(4, 100);
    chk("vld_gap", vld_gap inside {[2 * LAT + 2:2 * LAT + 3]}, 1);
    repeat (20) @(negedge clk);
    chk("no_extra_read", rd_lo_cnt, t0 + 2);

    push_read(8'h55, 8'h66);
    h0 = hi_snd_cnt;
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    int_in = 1'b0;
    for (int i = 0; i < 100 && hi_snd_cnt == h0; i++) @(negedge clk);
    chk("hi_snd_timeout", hi_snd_cnt > h0, 1);
    repeat (2) @(negedge clk);
    v0 = vld_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_held_init_done", init_done, 0);

    snd_cnt = 0;
    push_init();
    first_armed = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    wait_init(200);
    chk("pwr_wait_again", (first_snd_cyc - r) inside {[16:17]}, 1);
    chk("reinit_snd_count", snd_cnt, 3);
    chk("no_vld_after_rst", vld_cnt, v0);
    chk("cmd_q_drained", exp_cmd_q.size(), 0);
    chk("yaw_q_drained", exp_yaw_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
